mem_io_bus_switch: RTL

//  N-master byte-wide memory/IO switch between bus masters (CPU, HCI debug, DMA) and the shared RAM + HCI IO port.

---
 rtl/bus_pkg.sv | 18 +
 rtl/mem_io_bus_switch_if.sv | 41 ++++
 rtl/bus_arbiter.sv | 98 +++++++++
 rtl/mem_io_bus_switch.sv | 98 +++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared types for mem_io_bus_switch: IO space decode tag, read-return tag and arbiter state.
package bus_pkg;

  localparam logic [1:0]  IO_TAG       = 2'b11;
  localparam int unsigned MASTER_IDX_W = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } bus_state_e;

  typedef struct packed {
    logic                    valid;
    logic [MASTER_IDX_W-1:0] master;
    logic                    is_io;
  } ret_tag_t;

endpackage

// File: rtl/mem_io_bus_switch_if.sv
// Bus bundle between the masters, the switch and the shared RAM / HCI IO port.
interface mem_io_bus_switch_if #(
  parameter int unsigned N_MASTERS      = 2,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned RAM_ADDR_WIDTH = 17,
  parameter int unsigned IO_SEL_WIDTH   = 3
);
  logic [N_MASTERS-1:0]            m_req;
  logic [N_MASTERS-1:0]            m_lock;
  logic [N_MASTERS-1:0]            m_wr;
  logic [N_MASTERS*ADDR_WIDTH-1:0] m_addr;
  logic [N_MASTERS*8-1:0]          m_wdata;
  logic [N_MASTERS-1:0]            m_gnt;
  logic [N_MASTERS-1:0]            m_rvalid;
  logic [7:0]                      m_rdata;

  logic                      ram_en;
  logic                      ram_wr;
  logic [RAM_ADDR_WIDTH-1:0] ram_a;
  logic [7:0]                ram_din;
  logic [7:0]                ram_dout;

  logic                    io_en;
  logic                    io_wr;
  logic [IO_SEL_WIDTH-1:0] io_sel;
  logic [7:0]              io_din;
  logic [7:0]              io_dout;
  logic                    io_full;

  modport slave (
    input  m_req, m_lock, m_wr, m_addr, m_wdata, ram_dout, io_dout, io_full,
    output m_gnt, m_rvalid, m_rdata,
           ram_en, ram_wr, ram_a, ram_din, io_en, io_wr, io_sel, io_din
  );

  modport master (
    output m_req, m_lock, m_wr, m_addr, m_wdata, ram_dout, io_dout, io_full,
    input  m_gnt, m_rvalid, m_rdata,
           ram_en, ram_wr, ram_a, ram_din, io_en, io_wr, io_sel, io_din
  );
endinterface

// File: rtl/bus_arbiter.sv
// Ownership arbiter: one-hot grant among eligible masters with locked bursts.
// BUS_ROUND_ROBIN_EN selects round-robin IDLE arbitration; default is fixed priority (index 0 first).
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned N_MASTERS = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic [N_MASTERS-1:0] req,
  input  logic [N_MASTERS-1:0] elig,
  input  logic [N_MASTERS-1:0] lock,
  output logic [N_MASTERS-1:0] gnt
);
  localparam int unsigned IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  bus_state_e       state, state_nxt;
  logic [IDX_W-1:0] owner, owner_nxt;
  logic [IDX_W-1:0] win;
  logic             win_vld;

`ifdef BUS_ROUND_ROBIN_EN
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] gidx;

  always_comb begin
    int unsigned idx;
    idx     = 0;
    win     = '0;
    win_vld = 1'b0;
    for (int unsigned k = 0; k < N_MASTERS; k++) begin
      idx = (32'(rr_ptr) + k) % N_MASTERS;
      if (!win_vld && elig[idx]) begin
        win_vld = 1'b1;
        win     = IDX_W'(idx);
      end
    end
  end

  assign gidx = (state == OWNED) ? owner : win;

  // Pointer only moves once ownership is released, so a burst counts as one turn.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)
      rr_ptr <= '0;
    else if (|gnt && state_nxt == IDLE)
      rr_ptr <= (32'(gidx) == N_MASTERS - 1) ? '0 : gidx + 1'b1;
  end
`else
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    for (int unsigned k = 0; k < N_MASTERS; k++) begin
      if (!win_vld && elig[k]) begin
        win_vld = 1'b1;
        win     = IDX_W'(k);
      end
    end
  end
`endif

  always_comb begin
    gnt       = '0;
    state_nxt = state;
    owner_nxt = owner;
    if (rst_n_in) begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            gnt[win] = 1'b1;
            if (lock[win]) begin
              state_nxt = OWNED;
              owner_nxt = win;
            end
          end
        end
        OWNED: begin
          if (elig[owner])
            gnt[owner] = 1'b1;
          if (!req[owner] || (elig[owner] && !lock[owner]))
            state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= IDLE;
      owner <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
    end
  end

endmodule

// File: rtl/mem_io_bus_switch.sv
// N-master byte switch onto shared RAM and HCI IO with address decode and tagged 1-cycle read return.
// BUS_ROUND_ROBIN_EN (in bus_arbiter) switches IDLE arbitration to round-robin.
module mem_io_bus_switch #(
  parameter int unsigned N_MASTERS      = 2,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned RAM_ADDR_WIDTH = 17,
  parameter logic [1:0]  IO_TAG         = bus_pkg::IO_TAG,
  parameter int unsigned IO_SEL_WIDTH   = 3
) (
  input logic                clk_in,
  input logic                rst_n_in,
  mem_io_bus_switch_if.slave bus
);
  import bus_pkg::*;

  localparam int unsigned IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  logic [N_MASTERS-1:0]  elig;
  logic [N_MASTERS-1:0]  gnt;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  sel_wr;
  logic [7:0]            sel_wdata;
  logic [IDX_W-1:0]      sel_idx;
  logic                  any_gnt;
  logic                  sel_io;
  ret_tag_t              tag;

  // An IO write into a full HCI buffer stalls only its own master.
  always_comb begin
    logic [ADDR_WIDTH-1:0] a;
    a    = '0;
    elig = '0;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      a       = bus.m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      elig[i] = bus.m_req[i] &
                ~(bus.m_wr[i] & (a[RAM_ADDR_WIDTH -: 2] == IO_TAG) & bus.io_full);
    end
  end

  bus_arbiter #(
    .N_MASTERS (N_MASTERS)
  ) u_arbiter (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .req      (bus.m_req),
    .elig     (elig),
    .lock     (bus.m_lock),
    .gnt      (gnt)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wr    = 1'b0;
    sel_wdata = '0;
    sel_idx   = '0;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      if (gnt[i]) begin
        sel_addr  = bus.m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wr    = bus.m_wr[i];
        sel_wdata = bus.m_wdata[i*8 +: 8];
        sel_idx   = IDX_W'(i);
      end
    end
  end

  assign any_gnt = |gnt;
  assign sel_io  = any_gnt && (sel_addr[RAM_ADDR_WIDTH -: 2] == IO_TAG);

  assign bus.m_gnt   = gnt;
  assign bus.ram_en  = any_gnt && !sel_io;
  assign bus.ram_wr  = bus.ram_en && sel_wr;
  assign bus.ram_a   = bus.ram_en ? sel_addr[RAM_ADDR_WIDTH-1:0] : '0;
  assign bus.ram_din = bus.ram_wr ? sel_wdata : '0;
  assign bus.io_en   = sel_io;
  assign bus.io_wr   = sel_io && sel_wr;
  assign bus.io_sel  = sel_io ? sel_addr[IO_SEL_WIDTH-1:0] : '0;
  assign bus.io_din  = bus.io_wr ? sel_wdata : '0;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      tag <= '0;
    end else begin
      tag.valid  <= any_gnt && !sel_wr;
      tag.master <= MASTER_IDX_W'(sel_idx);
      tag.is_io  <= sel_io;
    end
  end

  always_comb begin
    bus.m_rvalid = '0;
    bus.m_rdata  = '0;
    if (tag.valid) begin
      bus.m_rvalid[IDX_W'(tag.master)] = 1'b1;
      bus.m_rdata = tag.is_io ? bus.io_dout : bus.ram_dout;
    end
  end

endmodule
